// File: rtl/tessia_ctrl_pkg.sv
// Shared encodings for the TessiaX64 decode-stage control unit: instruction
// classes, vector subclasses, ALU control codes and Funct[4:1] opcodes.
package tessia_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_DP  = 2'b00,
    OP_MEM = 2'b01,
    OP_BR  = 2'b10,
    OP_VEC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    VOP_DP   = 2'b00,
    VOP_MEM  = 2'b01,
    VOP_RSV2 = 2'b10,
    VOP_RSV3 = 2'b11
  } vop_e;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_MUL = 4'b0010,
    ALU_ORR = 4'b0011,
    ALU_MOV = 4'b0110
  } alu_ctrl_e;

  typedef enum logic {
    SEQ_IDLE,
    SEQ_BURST
  } seq_state_e;

  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_MUL = 4'b0000;
  localparam logic [3:0] FN_ORR = 4'b1100;
  localparam logic [3:0] FN_MOV = 4'b1101;
  localparam logic [3:0] FN_CMP = 4'b1010;

  // All ones; truncated to the register-address width at the point of use.
  localparam logic [31:0] PC_REG_IDX = '1;

endpackage

// File: rtl/alu_decoder.sv
// Funct[4:1] to ALU control mapping shared by scalar and vector paths.
// Vector MUL is only legal when VEC_MUL_EN is defined.
module alu_decoder
  import tessia_ctrl_pkg::*;
(
  input  logic [3:0] funct_op,
  input  logic       is_vector,
  output logic [3:0] alu_ctrl,
  output logic       no_write,
  output logic       illegal
);

`ifdef VEC_MUL_EN
  logic unused_is_vector;
  assign unused_is_vector = is_vector;
`endif

  always_comb begin
    alu_ctrl = ALU_ADD;
    no_write = 1'b0;
    illegal  = 1'b0;
    unique case (funct_op)
      FN_ADD: alu_ctrl = ALU_ADD;
      FN_SUB: alu_ctrl = ALU_SUB;
      FN_ORR: alu_ctrl = ALU_ORR;
      FN_MOV: alu_ctrl = ALU_MOV;
      FN_CMP: begin
        alu_ctrl = ALU_SUB;
        no_write = 1'b1;
      end
      FN_MUL: begin
        alu_ctrl = ALU_MUL;
`ifndef VEC_MUL_EN
        if (is_vector) begin
          alu_ctrl = ALU_ADD;
          illegal  = 1'b1;
        end
`endif
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/vector_sequencing_control_unit.sv
// Decode-stage control unit with a beat sequencer for multi-beat vector ops.
// VEC_MUL_EN (see alu_decoder) enables vector MUL.
module vector_sequencing_control_unit
  import tessia_ctrl_pkg::*;
#(
  parameter  int unsigned VEC_LANES  = 4,
  parameter  int unsigned ALU_LANES  = 2,
  parameter  int unsigned REG_ADDR_W = 5,
  localparam int unsigned BEATS      = VEC_LANES / ALU_LANES,
  localparam int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  InstrValidD,
  input  logic                  FlushD,
  input  logic [1:0]            Op,
  input  logic [1:0]            VectorOp,
  input  logic [5:0]            Funct,
  input  logic [REG_ADDR_W-1:0] Rd,
  output logic                  PCSrcD,
  output logic                  RegWriteD,
  output logic                  VectorRegWriteD,
  output logic                  VectorMemWriteD,
  output logic                  MemToRegD,
  output logic                  MemWriteD,
  output logic                  BranchD,
  output logic                  ALUSrcD,
  output logic                  NoWrite,
  output logic [1:0]            ImmSrcD,
  output logic [1:0]            RegSrcD,
  output logic [3:0]            ALUControlD,
  output logic                  IllegalD,
  output logic                  StallSeqD,
  output logic [BEAT_W-1:0]     VecBeatD,
  output logic                  VecLastD
);

  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);
  localparam logic [REG_ADDR_W-1:0] PC_REG    = REG_ADDR_W'(PC_REG_IDX);

  op_e  op;
  vop_e vop;
  logic active;
  assign op     = op_e'(Op);
  assign vop    = vop_e'(VectorOp);
  assign active = InstrValidD & ~FlushD & ~reset;

  logic       reg_w, vreg_w, vmem_w, mem2reg, mem_w, br, alu_src;
  logic [1:0] imm_src, reg_src;
  logic       use_alu_dec, is_vec, class_ill;
  logic [3:0] dec_ctrl, non_dp_ctrl;
  logic       dec_nowrite, dec_ill, illegal, legal;

  alu_decoder u_alu_decoder (
    .funct_op  (Funct[4:1]),
    .is_vector (is_vec),
    .alu_ctrl  (dec_ctrl),
    .no_write  (dec_nowrite),
    .illegal   (dec_ill)
  );

  always_comb begin
    reg_w       = 1'b0;
    vreg_w      = 1'b0;
    vmem_w      = 1'b0;
    mem2reg     = 1'b0;
    mem_w       = 1'b0;
    br          = 1'b0;
    alu_src     = 1'b0;
    imm_src     = 2'b00;
    reg_src     = 2'b00;
    use_alu_dec = 1'b0;
    is_vec      = 1'b0;
    class_ill   = 1'b0;
    unique case (op)
      OP_DP: begin
        reg_w       = 1'b1;
        alu_src     = Funct[5];
        use_alu_dec = 1'b1;
      end
      OP_MEM: begin
        alu_src = 1'b1;
        imm_src = 2'b01;
        if (Funct[0]) begin
          reg_w   = 1'b1;
          mem2reg = 1'b1;
        end else begin
          mem_w   = 1'b1;
          reg_src = 2'b10;
        end
      end
      OP_BR: begin
        br      = 1'b1;
        alu_src = 1'b1;
        imm_src = 2'b10;
        reg_src = 2'b01;
      end
      OP_VEC: begin
        is_vec = 1'b1;
        unique case (vop)
          VOP_DP: begin
            vreg_w      = 1'b1;
            alu_src     = Funct[5];
            use_alu_dec = 1'b1;
          end
          VOP_MEM: begin
            alu_src = 1'b1;
            imm_src = 2'b01;
            if (Funct[0]) begin
              vreg_w  = 1'b1;
              mem2reg = 1'b1;
            end else begin
              vmem_w  = 1'b1;
              reg_src = 2'b10;
            end
          end
          default: class_ill = 1'b1;
        endcase
      end
    endcase
  end

  assign non_dp_ctrl = Funct[5] ? ALU_ADD : ALU_SUB;
  assign illegal     = class_ill | (use_alu_dec & dec_ill);
  assign legal       = ~illegal;

  seq_state_e        state_q, state_d;
  logic [BEAT_W-1:0] cnt_q, cnt_d;
  logic              seq_last, seq_stall;
  logic              vec_ok;

  assign vec_ok = active & is_vec & legal;

  // Decode sees the held instruction throughout a burst, so the burst only
  // advances on cycles where that instruction is actually active.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    seq_last  = 1'b0;
    seq_stall = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (vec_ok) begin
          if (BEATS == 1) begin
            seq_last = 1'b1;
          end else begin
            seq_stall = 1'b1;
            state_d   = SEQ_BURST;
            cnt_d     = BEAT_W'(1);
          end
        end
      end
      SEQ_BURST: begin
        if (active) begin
          if (cnt_q == LAST_BEAT) begin
            seq_last = 1'b1;
            state_d  = SEQ_IDLE;
            cnt_d    = '0;
          end else begin
            seq_stall = 1'b1;
            cnt_d     = cnt_q + BEAT_W'(1);
          end
        end
      end
    endcase
    if (FlushD | reset) begin
      state_d = SEQ_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEQ_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic ok;
  assign ok = active & legal;

  assign RegWriteD       = ok & reg_w;
  assign VectorRegWriteD = ok & vreg_w;
  assign VectorMemWriteD = ok & vmem_w;
  assign MemWriteD       = ok & mem_w;
  assign BranchD         = ok & br;
  assign MemToRegD       = ok & mem2reg;
  assign ALUSrcD         = ok & alu_src;
  assign NoWrite         = ok & use_alu_dec & dec_nowrite;
  assign ImmSrcD         = ok ? imm_src : 2'b00;
  assign RegSrcD         = ok ? reg_src : 2'b00;
  assign ALUControlD     = ok ? (use_alu_dec ? dec_ctrl : non_dp_ctrl) : 4'b0000;
  assign PCSrcD          = ((Rd == PC_REG) & RegWriteD) | BranchD;
  assign IllegalD        = active & illegal;
  assign StallSeqD       = active & seq_stall;
  assign VecLastD        = active & seq_last;
  assign VecBeatD        = (active && state_q == SEQ_BURST) ? cnt_q : '0;

endmodule

// File: tb/tb_vector_sequencing_control_unit.sv
// Scoreboard bench for vector_sequencing_control_unit with VEC_LANES=8,
// ALU_LANES=2 (four beats per vector instruction).
module tb_vector_sequencing_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       InstrValidD = 1'b0;
  logic       FlushD = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [1:0] VectorOp = 2'b00;
  logic [5:0] Funct = 6'b0;
  logic [4:0] Rd = 5'd0;
  logic       PCSrcD, RegWriteD, VectorRegWriteD, VectorMemWriteD, MemToRegD;
  logic       MemWriteD, BranchD, ALUSrcD, NoWrite, IllegalD, StallSeqD, VecLastD;
  logic [1:0] ImmSrcD, RegSrcD, VecBeatD;
  logic [3:0] ALUControlD;

  vector_sequencing_control_unit #(
    .VEC_LANES  (8),
    .ALU_LANES  (2),
    .REG_ADDR_W (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .InstrValidD     (InstrValidD),
    .FlushD          (FlushD),
    .Op              (Op),
    .VectorOp        (VectorOp),
    .Funct           (Funct),
    .Rd              (Rd),
    .PCSrcD          (PCSrcD),
    .RegWriteD       (RegWriteD),
    .VectorRegWriteD (VectorRegWriteD),
    .VectorMemWriteD (VectorMemWriteD),
    .MemToRegD       (MemToRegD),
    .MemWriteD       (MemWriteD),
    .BranchD         (BranchD),
    .ALUSrcD         (ALUSrcD),
    .NoWrite         (NoWrite),
    .ImmSrcD         (ImmSrcD),
    .RegSrcD         (RegSrcD),
    .ALUControlD     (ALUControlD),
    .IllegalD        (IllegalD),
    .StallSeqD       (StallSeqD),
    .VecBeatD        (VecBeatD),
    .VecLastD        (VecLastD)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcsrc, regw, vregw, vmemw, m2r, memw, br, alusrc, nowr;
    logic [1:0] imm, regsrc;
    logic [3:0] alu;
    logic       ill, stall;
    logic [1:0] beat;
    logic       last;
  } exp_t;

  typedef struct {
    exp_t  e;
    string name;
  } item_t;

  item_t sbq[$];
  int    vectors = 0;
  int    miscompares = 0;

  function automatic exp_t mk(input logic pcsrc, regw, vregw, vmemw, m2r, memw, br,
                              alusrc, nowr, input logic [1:0] imm, regsrc,
                              input logic [3:0] alu, input logic ill);
    exp_t e;
    e = '0;
    e.pcsrc = pcsrc; e.regw = regw; e.vregw = vregw; e.vmemw = vmemw;
    e.m2r = m2r; e.memw = memw; e.br = br; e.alusrc = alusrc; e.nowr = nowr;
    e.imm = imm; e.regsrc = regsrc; e.alu = alu; e.ill = ill;
    return e;
  endfunction

  function automatic exp_t bt(input exp_t b, input logic [1:0] beat,
                              input logic stall, input logic last);
    exp_t e;
    e = b;
    e.beat = beat; e.stall = stall; e.last = last;
    return e;
  endfunction

  task automatic apply(input string nm, input logic rst, input logic valid,
                       input logic flush, input logic [1:0] op, input logic [1:0] vop,
                       input logic [5:0] fn, input logic [4:0] rd, input exp_t e);
    item_t it;
    @(posedge clk);
    #1;
    reset = rst; InstrValidD = valid; FlushD = flush;
    Op = op; VectorOp = vop; Funct = fn; Rd = rd;
    it.e = e;
    it.name = nm;
    sbq.push_back(it);
  endtask

  initial begin
    item_t it;
    exp_t  act;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        it  = sbq.pop_front();
        act = {PCSrcD, RegWriteD, VectorRegWriteD, VectorMemWriteD, MemToRegD, MemWriteD,
               BranchD, ALUSrcD, NoWrite, ImmSrcD, RegSrcD, ALUControlD, IllegalD,
               StallSeqD, VecBeatD, VecLastD};
        vectors++;
        if (act !== it.e) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.e);
        end
      end
    end
  end

  exp_t Z, S_ADD, S_MOV_PC, S_SUBI, S_ORR, S_CMP, S_LDR, S_LDR_PC, S_STR, S_B, ILL;
  exp_t V_ADD, V_STR, V_LDR, V_MUL;

  initial begin
    Z        = '0;
    S_ADD    = mk(0,1,0,0,0,0,0,0,0,2'b00,2'b00,4'h0,0);
    S_MOV_PC = mk(1,1,0,0,0,0,0,1,0,2'b00,2'b00,4'h6,0);
    S_SUBI   = mk(0,1,0,0,0,0,0,1,0,2'b00,2'b00,4'h1,0);
    S_ORR    = mk(0,1,0,0,0,0,0,0,0,2'b00,2'b00,4'h3,0);
    S_CMP    = mk(0,1,0,0,0,0,0,0,1,2'b00,2'b00,4'h1,0);
    S_LDR    = mk(0,1,0,0,1,0,0,1,0,2'b01,2'b00,4'h1,0);
    S_LDR_PC = mk(1,1,0,0,1,0,0,1,0,2'b01,2'b00,4'h0,0);
    S_STR    = mk(0,0,0,0,0,1,0,1,0,2'b01,2'b10,4'h0,0);
    S_B      = mk(1,0,0,0,0,0,1,1,0,2'b10,2'b01,4'h1,0);
    ILL      = mk(0,0,0,0,0,0,0,0,0,2'b00,2'b00,4'h0,1);
    V_ADD    = mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,4'h0,0);
    V_STR    = mk(0,0,0,1,0,0,0,1,0,2'b01,2'b10,4'h0,0);
    V_LDR    = mk(0,0,1,0,1,0,0,1,0,2'b01,2'b00,4'h1,0);
    V_MUL    = mk(0,0,1,0,0,0,0,0,0,2'b00,2'b00,4'h2,0);

    // reset holds every output low even with a valid vector instruction
    apply("reset0", 1, 1, 0, 2'b11, 2'b00, 6'b001000, 5'd3, Z);
    apply("reset1", 1, 1, 0, 2'b11, 2'b00, 6'b001000, 5'd3, Z);

    apply("add_reg",  0, 1, 0, 2'b00, 2'b00, 6'b001000, 5'd3,  S_ADD);
    apply("mov_pc",   0, 1, 0, 2'b00, 2'b00, 6'b111010, 5'd31, S_MOV_PC);
    apply("sub_imm",  0, 1, 0, 2'b00, 2'b00, 6'b100100, 5'd1,  S_SUBI);
    apply("orr_reg",  0, 1, 0, 2'b00, 2'b00, 6'b011000, 5'd7,  S_ORR);
    apply("cmp",      0, 1, 0, 2'b00, 2'b00, 6'b010100, 5'd2,  S_CMP);
    apply("ldr",      0, 1, 0, 2'b01, 2'b00, 6'b011001, 5'd4,  S_LDR);
    apply("ldr_pc",   0, 1, 0, 2'b01, 2'b00, 6'b100001, 5'd31, S_LDR_PC);
    apply("str",      0, 1, 0, 2'b01, 2'b00, 6'b111000, 5'd5,  S_STR);
    apply("branch",   0, 1, 0, 2'b10, 2'b00, 6'b000000, 5'd0,  S_B);
    apply("not_valid",0, 0, 0, 2'b00, 2'b00, 6'b001000, 5'd31, Z);
    apply("ill_dp",   0, 1, 0, 2'b00, 2'b00, 6'b001110, 5'd3,  ILL);
    apply("ill_vop10",0, 1, 0, 2'b11, 2'b10, 6'b100000, 5'd3,  ILL);
    apply("ill_vop11",0, 1, 0, 2'b11, 2'b11, 6'b100001, 5'd31, ILL);

`ifdef VEC_MUL_EN
    for (int k = 0; k < 4; k++)
      apply("vmul_beat", 0, 1, 0, 2'b11, 2'b00, 6'b000000, 5'd6,
            bt(V_MUL, 2'(k), k < 3, k == 3));
`else
    apply("vmul_ill", 0, 1, 0, 2'b11, 2'b00, 6'b000000, 5'd6, ILL);
`endif
    apply("smul", 0, 1, 0, 2'b00, 2'b00, 6'b000000, 5'd6,
          mk(0,1,0,0,0,0,0,0,0,2'b00,2'b00,4'h2,0));

    for (int k = 0; k < 4; k++)
      apply("vadd_beat", 0, 1, 0, 2'b11, 2'b00, 6'b001000, 5'd9,
            bt(V_ADD, 2'(k), k < 3, k == 3));
    apply("after_vadd", 0, 1, 0, 2'b00, 2'b00, 6'b001000, 5'd3, S_ADD);

    // flush at beat 1 restarts the held STR from beat 0
    apply("vstr_b0",    0, 1, 0, 2'b11, 2'b01, 6'b100000, 5'd8, bt(V_STR, 2'd0, 1, 0));
    apply("vstr_flush", 0, 1, 1, 2'b11, 2'b01, 6'b100000, 5'd8, Z);
    for (int k = 0; k < 4; k++)
      apply("vstr_beat", 0, 1, 0, 2'b11, 2'b01, 6'b100000, 5'd8,
            bt(V_STR, 2'(k), k < 3, k == 3));

    // invalid cycle mid-burst freezes the beat counter
    apply("vldr_b0",  0, 1, 0, 2'b11, 2'b01, 6'b000001, 5'd10, bt(V_LDR, 2'd0, 1, 0));
    apply("vldr_b1",  0, 1, 0, 2'b11, 2'b01, 6'b000001, 5'd10, bt(V_LDR, 2'd1, 1, 0));
    apply("vldr_inv", 0, 0, 0, 2'b11, 2'b01, 6'b000001, 5'd10, Z);
    apply("vldr_b2",  0, 1, 0, 2'b11, 2'b01, 6'b000001, 5'd10, bt(V_LDR, 2'd2, 1, 0));
    apply("vldr_b3",  0, 1, 0, 2'b11, 2'b01, 6'b000001, 5'd10, bt(V_LDR, 2'd3, 0, 1));

    apply("vadd2_b0",  0, 1, 0, 2'b11, 2'b00, 6'b101000, 5'd9,
          bt(mk(0,0,1,0,0,0,0,1,0,2'b00,2'b00,4'h0,0), 2'd0, 1, 0));
    apply("vadd2_b1",  0, 1, 0, 2'b11, 2'b00, 6'b101000, 5'd9,
          bt(mk(0,0,1,0,0,0,0,1,0,2'b00,2'b00,4'h0,0), 2'd1, 1, 0));
    apply("vadd2_rst", 1, 1, 0, 2'b11, 2'b00, 6'b101000, 5'd9, Z);
    for (int k = 0; k < 4; k++)
      apply("vadd2_beat", 0, 1, 0, 2'b11, 2'b00, 6'b101000, 5'd9,
            bt(mk(0,0,1,0,0,0,0,1,0,2'b00,2'b00,4'h0,0), 2'(k), k < 3, k == 3));
    apply("final_b", 0, 1, 0, 2'b10, 2'b00, 6'b000000, 5'd0, S_B);

    for (int i = 0; i < 20 && sbq.size() != 0; i++) @(negedge clk);
    #1;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending expected 0 pending", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/vector_sequencing_control_unit.md
# vector_sequencing_control_unit

Second-generation decode-stage control unit for the TessiaX64 pipeline. It decodes scalar data-processing, load/store and branch instructions, and vector data-processing and vector load/store instructions, into Decode-stage control signals. Vector instructions operating on VEC_LANES elements are executed over VEC_LANES/ALU_LANES beats on a narrower vector datapath. A beat sequencer stalls Fetch and Decode until the last beat issues. Encodings not in the decode set raise IllegalD and do not produce ALUControlD = x.

## Interface
- VEC_LANES, 4: elements per vector register; power of two, at least 1.
- ALU_LANES, 2: elements processed per beat; power of two; divides VEC_LANES.
- REG_ADDR_W, 5: register-address width; the PC register index is all ones.
- Derived BEATS = VEC_LANES/ALU_LANES and BEAT_W = max(1, clog2(BEATS)).

Ports (clock and reset first; one clock; reset is synchronous and active-high):
- clk, input, 1: single clock, rising edge.
- reset, input, 1: synchronous, active-high.
- InstrValidD, input, 1: the Decode register holds a valid instruction.
- FlushD, input, 1: squash the Decode stage.
- Op, input, 2: instruction class.
- VectorOp, input, 2: vector subclass, instruction bits [41:40].
- Funct, input, 6: function field.
- Rd, input, REG_ADDR_W: destination register.
- PCSrcD, RegWriteD, VectorRegWriteD, VectorMemWriteD, MemToRegD, MemWriteD, BranchD, ALUSrcD, NoWrite: outputs, 1 bit each, same meaning as the first-generation unit.
- ImmSrcD, output, 2: immediate format.
- RegSrcD, output, 2: register source select.
- ALUControlD, output, 4: ALU operation.
- IllegalD, output, 1: unsupported encoding.
- StallSeqD, output, 1: hold the Fetch and Decode registers.
- VecBeatD, output, BEAT_W: current beat index.
- VecLastD, output, 1: this is the final beat of a vector instruction.

## Operation
- Main decode:
  - Op=00: scalar data processing; Funct[5] selects the immediate form.
  - Op=01: LDR when Funct[0]=1, STR when Funct[0]=0.
  - Op=10: B.
  - Op=11 with VectorOp=00: vector data processing.
  - Op=11 with VectorOp=01: vector LDR (Funct[0]=1) or vector STR (Funct[0]=0).
  - Op=11 with VectorOp=1x: illegal.
- ALU decode from Funct[4:1]:
  - 0100 ADD gives 0000.
  - 0010 SUB gives 0001.
  - 0000 MUL gives 0010.
  - 1100 ORR gives 0011.
  - 1101 MOV gives 0110.
  - 1010 CMP gives 0001 with NoWrite=1.
  - Any other code sets IllegalD=1 and ALUControlD=0000.
- Non-DP instructions: ALUControlD = Funct[5] ? 0000 : 0001.
- IllegalD=1 forces all write, branch and PCSrc outputs to 0.
- PCSrcD = ((Rd == all ones) & RegWriteD) | BranchD.
- Every control output is gated to 0 when InstrValidD=0, FlushD=1 or reset=1.
- Sequencer states:
  - IDLE: a legal vector instruction with BEATS>1 goes to BURST with beat counter 1. Scalar instructions stay in IDLE.
  - BURST: increment the counter each cycle. On VecLastD go to IDLE.
  - FlushD or reset in any state: go to IDLE with counter 0 at the next edge.
- VecBeatD = 0 in IDLE, otherwise the counter value.
- Vector controls repeat on every beat; scalar outputs stay 0 during a vector instruction.

## Timing
- Decode outputs are combinational from the held instruction plus the registered beat state. Latency is 0 cycles.
- A vector instruction accepted at cycle T:
  - Beat k is presented at T+k.
  - StallSeqD=1 at T through T+BEATS-2.
  - VecLastD=1 at T+BEATS-1.
  - The next instruction is decoded at T+BEATS.
- BEATS=1: VecLastD=1 in the same cycle, StallSeqD never asserts, and the FSM stays in IDLE.
- Scalar instructions: VecLastD=0 and StallSeqD=0.
- FlushD mid-burst: outputs are 0 and StallSeqD=0 in that cycle; the next cycle is in IDLE.
- reset mid-burst: same behaviour as FlushD.
- Reset values: every output 0; state IDLE; counter 0.
- InstrValidD=0 while in BURST: the burst is frozen, no advance, outputs 0. It resumes when InstrValidD returns to 1.

## Configuration
- VEC_MUL_EN defined: vector Funct[4:1]=0000 decodes as vector MUL (0010).
- VEC_MUL_EN undefined:
  - Vector Funct[4:1]=0000 raises IllegalD and starts no burst.
  - Scalar MUL is unaffected.

## Structure
- Package tessia_ctrl_pkg:
  - op_e (Op classes)
  - vop_e (VectorOp)
  - alu_ctrl_e (ALUControl codes)
  - Funct[4:1] opcode constants
  - the PC register index constant
- Sub-module alu_decoder: combinational Funct-to-ALUControlD/NoWrite/illegal mapping, shared by the scalar and vector paths, with the VEC_MUL_EN gate inside it.
- The top level holds the main decoder, the beat counter and FSM, and the output gating.

## Test plan
- Scalar ADD register (Op=00, Funct=001000), Rd=3: RegWriteD=1, ALUControlD=0000, PCSrcD=0, StallSeqD=0.
- MOV into Rd=11111: PCSrcD=1, ALUControlD=0110.
- Vector ADD with VEC_LANES=8, ALU_LANES=2:
  - VecBeatD sequence is 0,1,2,3.
  - StallSeqD=1 on the first three cycles.
  - VecLastD=1 on the fourth cycle.
  - VectorRegWriteD=1 on all four cycles.
  - The next instruction decodes in the fifth cycle.
- FlushD at beat 1 of a 4-beat vector STR: that cycle has all outputs 0; the next cycle is in IDLE with VecBeatD=0.
- Funct[4:1]=0111 on Op=00, then Op=11/VectorOp=10: IllegalD=1, RegWriteD=0 and MemWriteD=0 on both.
- Vector MUL: without VEC_MUL_EN gives IllegalD=1 and no stall; with VEC_MUL_EN gives ALUControlD=0010 and a full burst.
